// File: rtl/apb4_reg_bridge_pkg.sv
// Shared types and constants for the APB4 register bridge.
package apb4_reg_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [31:0] TMO_RDATA_DEFAULT = 32'hdead_1eaf;

endpackage

// File: rtl/reg_tmo_wdog.sv
// Request watchdog: counts wait cycles without ack and fires one cycle
// when the programmable limit is reached. A limit of zero disables it.
module reg_tmo_wdog #(
    parameter int TMO_WIDTH = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 run_i,
    input  logic                 ack_i,
    input  logic [TMO_WIDTH-1:0] limit_i,
    output logic                 tmo_o
);

    logic [TMO_WIDTH-1:0] cnt_q;

    // Held at zero outside the wait phase, so every wait starts from 0.
    // Saturates so a long disabled wait can never wrap into a false match.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (!run_i) begin
            cnt_q <= '0;
        end else if (!ack_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + TMO_WIDTH'(1);
        end
    end

    assign tmo_o = run_i && !ack_i && (limit_i != '0) &&
                   (cnt_q == (limit_i - TMO_WIDTH'(1)));

endmodule

// File: rtl/apb4_reg_bridge_fsm.sv
// APB4 completer that turns each transfer into one req/ack transaction to the
// register slave, with a programmable timeout and first-error capture.
//
// state  | meaning
// S_IDLE | waiting for an APB setup phase
// S_WAIT | request presented to the slave, waiting for ack or timeout
// S_RESP | PREADY high for one cycle with PRDATA/PSLVERR
module apb4_reg_bridge_fsm
    import apb4_reg_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 64,
    parameter int          DATA_WIDTH    = 32,
    parameter int          TMO_WIDTH     = 16,
    parameter int          TMO_CNT_WIDTH = 8,
    parameter logic [31:0] TMO_RDATA     = TMO_RDATA_DEFAULT
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    input  logic [2:0]                PPROT,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      fsm__slv__req_vld,
    output logic [ADDR_WIDTH-1:0]     fsm__slv__addr,
    output logic                      fsm__slv__wr_en,
    output logic                      fsm__slv__rd_en,
    output logic [DATA_WIDTH-1:0]     fsm__slv__wr_data,
    output logic [DATA_WIDTH/8-1:0]   fsm__slv__wr_strb,
    output logic [2:0]                fsm__slv__prot,
    output logic                      fsm__slv__sync_reset,
    input  logic                      slv__fsm__ack_vld,
    input  logic [DATA_WIDTH-1:0]     slv__fsm__rd_data,
    input  logic                      slv__fsm__err,
    input  logic [TMO_WIDTH-1:0]      cfg_tmo_cycles,
    input  logic                      clear,
    output logic                      interrupt,
    output logic [ADDR_WIDTH-1:0]     tmo_addr,
    output logic                      tmo_wr,
    output logic [TMO_CNT_WIDTH-1:0]  tmo_cnt
);

    localparam int                    STRB_WIDTH  = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] TMO_RDATA_W = DATA_WIDTH'(TMO_RDATA);

    state_e                   state_q;
    logic                     wr_q;
    logic                     req_vld_q;
    logic                     wr_en_q;
    logic                     rd_en_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;
    logic [STRB_WIDTH-1:0]    wr_strb_q;
    logic [2:0]               prot_q;
    logic                     sync_reset_q;
    logic                     pready_q;
    logic                     pslverr_q;
    logic [DATA_WIDTH-1:0]    prdata_q;
    logic                     irq_q;
    logic [ADDR_WIDTH-1:0]    tmo_addr_q;
    logic                     tmo_wr_q;
    logic [TMO_CNT_WIDTH-1:0] tmo_cnt_q;
    logic                     ack;
    logic                     tmo_fire;

    assign ack = req_vld_q && slv__fsm__ack_vld;

    reg_tmo_wdog #(
        .TMO_WIDTH (TMO_WIDTH)
    ) u_wdog (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .run_i   (state_q == S_WAIT),
        .ack_i   (ack),
        .limit_i (cfg_tmo_cycles),
        .tmo_o   (tmo_fire)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            req_vld_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
            prot_q       <= '0;
            sync_reset_q <= 1'b0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            prdata_q     <= '0;
        end else begin
            sync_reset_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (PSEL && !PENABLE) begin
                        addr_q    <= PADDR;
                        wr_data_q <= PWDATA;
                        wr_strb_q <= PWRITE ? PSTRB : '0;
                        prot_q    <= PPROT;
                        wr_q      <= PWRITE;
                        req_vld_q <= 1'b1;
                        wr_en_q   <= PWRITE;
                        rd_en_q   <= !PWRITE;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (ack) begin
                        prdata_q  <= wr_q ? '0 : slv__fsm__rd_data;
                        pslverr_q <= slv__fsm__err;
                        pready_q  <= 1'b1;
                        req_vld_q <= 1'b0;
                        wr_en_q   <= 1'b0;
                        rd_en_q   <= 1'b0;
                        state_q   <= S_RESP;
                    end else if (tmo_fire) begin
                        prdata_q     <= TMO_RDATA_W;
                        pslverr_q    <= 1'b1;
                        pready_q     <= 1'b1;
                        sync_reset_q <= 1'b1;
                        req_vld_q    <= 1'b0;
                        wr_en_q      <= 1'b0;
                        rd_en_q      <= 1'b0;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A timeout beats a concurrent clear: it restarts the capture from scratch.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_q      <= 1'b0;
            tmo_addr_q <= '0;
            tmo_wr_q   <= 1'b0;
            tmo_cnt_q  <= '0;
        end else if (tmo_fire) begin
            irq_q <= 1'b1;
            if (clear || !irq_q) begin
                tmo_addr_q <= addr_q;
                tmo_wr_q   <= wr_q;
            end
            if (clear) begin
                tmo_cnt_q <= TMO_CNT_WIDTH'(1);
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_CNT_WIDTH'(1);
            end
        end else if (clear) begin
            irq_q      <= 1'b0;
            tmo_addr_q <= '0;
            tmo_wr_q   <= 1'b0;
            tmo_cnt_q  <= '0;
        end
    end

    assign PRDATA               = prdata_q;
    assign PREADY               = pready_q;
    assign PSLVERR              = pslverr_q;
    assign fsm__slv__req_vld    = req_vld_q;
    assign fsm__slv__addr       = addr_q;
    assign fsm__slv__wr_en      = wr_en_q;
    assign fsm__slv__rd_en      = rd_en_q;
    assign fsm__slv__wr_data    = wr_data_q;
    assign fsm__slv__wr_strb    = wr_strb_q;
    assign fsm__slv__prot       = prot_q;
    assign fsm__slv__sync_reset = sync_reset_q;
    assign interrupt            = irq_q;
    assign tmo_addr             = tmo_addr_q;
    assign tmo_wr               = tmo_wr_q;
    assign tmo_cnt              = tmo_cnt_q;

endmodule
